traffic_controller_n: RTL and testbench

Parametrised N-approach traffic-light sequencer; the next-generation intersection controller. Cycles green → yellow → all-red through N_DIR approaches, with durations counted in `tick` strobes rather than raw clocks, and skips approaches with no vehicle demand. Outputs are registered 3-bit light codes per approach and drive the board light I/O directly.

---
 rtl/traffic_pkg.sv | 30 +++
 rtl/next_dir_arbiter.sv | 29 ++
 rtl/traffic_controller_n.sv | 141 ++++++++++++++
 tb/tb_traffic_controller_n.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared light codes, phase encoding and per-approach lamp decode
// for the N-approach traffic sequencer (flash option: TRAFFIC_FLASH_EN).
package traffic_pkg;

    localparam logic [2:0] LT_GREEN  = 3'b001;
    localparam logic [2:0] LT_YELLOW = 3'b010;
    localparam logic [2:0] LT_RED    = 3'b100;
    localparam logic [2:0] LT_OFF    = 3'b000;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2,
        PH_FLASH  = 2'd3
    } phase_t;

    function automatic logic [2:0] lamp(
        input phase_t ph,
        input logic   mine,
        input logic   flash_on
    );
        unique case (ph)
            PH_GREEN:  return mine ? LT_GREEN : LT_RED;
            PH_YELLOW: return mine ? LT_YELLOW : LT_RED;
            PH_ALLRED: return LT_RED;
            PH_FLASH:  return flash_on ? LT_YELLOW : LT_OFF;
        endcase
    endfunction

endpackage

// File: rtl/next_dir_arbiter.sv
// Rotating-priority search over vehicle demand, starting just after
// the current approach and wrapping back round to it.
module next_dir_arbiter #(
    parameter int N_DIR = 4
) (
    input  logic [N_DIR-1:0]         sense,
    input  logic [$clog2(N_DIR)-1:0] cur,
    output logic [$clog2(N_DIR)-1:0] nxt,
    output logic                     any
);

    localparam int DW = $clog2(N_DIR);

    logic [DW-1:0] idx;

    // Walk farthest-first so the nearest demanded approach wins.
    always_comb begin
        any = |sense;
        nxt = cur;
        idx = '0;
        for (int k = N_DIR; k >= 1; k--) begin
            idx = DW'((int'(cur) + k) % N_DIR);
            if (sense[idx]) begin
                nxt = idx;
            end
        end
    end

endmodule

// File: rtl/traffic_controller_n.sv
// N-approach green/yellow/all-red sequencer timed in tick strobes,
// skipping idle approaches; TRAFFIC_FLASH_EN adds the flash mode.
module traffic_controller_n
    import traffic_pkg::*;
#(
    parameter int N_DIR      = 4,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 4,
    parameter int ALLRED_CYC = 1,
    parameter int FLASH_CYC  = 2,
    parameter int CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst_an,
    input  logic                     tick,
    input  logic [N_DIR-1:0]         sense,
`ifdef TRAFFIC_FLASH_EN
    input  logic                     flash_req,
`endif
    output logic [3*N_DIR-1:0]       lights,
    output logic [$clog2(N_DIR)-1:0] active_dir,
    output logic [1:0]               phase
);

    localparam int DW = $clog2(N_DIR);

    localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] R_LAST = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] F_LAST = CNT_W'(FLASH_CYC - 1);

    localparam logic [3*N_DIR-1:0] RST_LIGHTS =
        {{(N_DIR-1){LT_RED}}, LT_GREEN};

    phase_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      dir_q, dir_d;
    logic               flash_on_q, flash_on_d;
    logic [3*N_DIR-1:0] lights_q, lights_d;

    logic [CNT_W-1:0]   last_val;
    logic               at_last;
    logic               flash_in;
    logic [DW-1:0]      arb_nxt;
    logic               arb_any;
    logic [DW-1:0]      rr_nxt;

`ifdef TRAFFIC_FLASH_EN
    assign flash_in = flash_req;
`else
    assign flash_in = 1'b0;
`endif

    next_dir_arbiter #(
        .N_DIR (N_DIR)
    ) u_arb (
        .sense (sense),
        .cur   (dir_q),
        .nxt   (arb_nxt),
        .any   (arb_any)
    );

    assign rr_nxt = (int'(dir_q) == N_DIR - 1) ? '0 : dir_q + DW'(1);

    always_comb begin
        unique case (state_q)
            PH_GREEN:  last_val = G_LAST;
            PH_YELLOW: last_val = Y_LAST;
            PH_ALLRED: last_val = R_LAST;
            PH_FLASH:  last_val = F_LAST;
        endcase
    end

    assign at_last = (cnt_q == last_val);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        flash_on_d = flash_on_q;
        if (tick) begin
            if (state_q == PH_FLASH) begin
                if (!flash_in) begin
                    state_d = PH_ALLRED;
                    cnt_d   = '0;
                end else if (at_last) begin
                    cnt_d      = '0;
                    flash_on_d = ~flash_on_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (flash_in) begin
                state_d    = PH_FLASH;
                cnt_d      = '0;
                flash_on_d = 1'b1;
            end else if (at_last) begin
                cnt_d = '0;
                unique case (state_q)
                    PH_GREEN:  state_d = PH_YELLOW;
                    PH_YELLOW: state_d = PH_ALLRED;
                    default: begin
                        state_d = PH_GREEN;
                        dir_d   = arb_any ? arb_nxt : rr_nxt;
                    end
                endcase
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Decode from next state so lights change on the same edge.
    always_comb begin
        lights_d = '0;
        for (int i = 0; i < N_DIR; i++) begin
            lights_d[3*i +: 3] =
                lamp(state_d, DW'(i) == dir_d, flash_on_d);
        end
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q    <= PH_GREEN;
            cnt_q      <= '0;
            dir_q      <= '0;
            flash_on_q <= 1'b0;
            lights_q   <= RST_LIGHTS;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            flash_on_q <= flash_on_d;
            lights_q   <= lights_d;
        end
    end

    assign lights     = lights_q;
    assign active_dir = dir_q;
    assign phase      = state_q;

endmodule

// File: tb/tb_traffic_controller_n.sv
// Self-checking bench: directed scenarios plus random tick/sense traffic
// compared against a countdown-based reference model.
module tb_traffic_controller_n;

    localparam int N  = 4;
    localparam int GC = 8;
    localparam int YC = 4;
    localparam int RC = 1;
    localparam int FC = 2;

    logic           clk;
    logic           rst_an;
    logic           tick;
    logic [N-1:0]   sense;
`ifdef TRAFFIC_FLASH_EN
    logic           flash_req;
`endif
    logic [3*N-1:0] lights;
    logic [1:0]     active_dir;
    logic [1:0]     phase;

    int errs   = 0;
    int checks = 0;

    // reference model: phase number, approach, ticks remaining in phase
    int m_ph;
    int m_dir;
    int m_rem;
    bit m_flash_on;

    traffic_controller_n #(
        .N_DIR      (N),
        .GREEN_CYC  (GC),
        .YELLOW_CYC (YC),
        .ALLRED_CYC (RC),
        .FLASH_CYC  (FC),
        .CNT_W      (8)
    ) dut (
        .clk        (clk),
        .rst_an     (rst_an),
        .tick       (tick),
        .sense      (sense),
`ifdef TRAFFIC_FLASH_EN
        .flash_req  (flash_req),
`endif
        .lights     (lights),
        .active_dir (active_dir),
        .phase      (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dur(input int ph);
        case (ph)
            0:       return GC;
            1:       return YC;
            2:       return RC;
            default: return FC;
        endcase
    endfunction

    function automatic int pick(input int cur, input logic [N-1:0] s);
        for (int k = 1; k <= N; k++) begin
            if (s[(cur + k) % N]) return (cur + k) % N;
        end
        return (cur + 1) % N;
    endfunction

    function automatic logic [3*N-1:0] exp_lights();
        logic [3*N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            logic [2:0] c;
            c = 3'b100;
            if (m_ph == 0 && i == m_dir) c = 3'b001;
            if (m_ph == 1 && i == m_dir) c = 3'b010;
            if (m_ph == 3) c = m_flash_on ? 3'b010 : 3'b000;
            v[3*i +: 3] = c;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_ph       = 0;
        m_dir      = 0;
        m_rem      = GC;
        m_flash_on = 1'b0;
    endtask

    task automatic model_edge(input bit t, input logic [N-1:0] s,
                              input bit fr);
        if (!t) return;
        if (m_ph == 3) begin
            if (!fr) begin
                m_ph  = 2;
                m_rem = RC;
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_flash_on = !m_flash_on;
                    m_rem      = FC;
                end
            end
        end else if (fr) begin
            m_ph       = 3;
            m_rem      = FC;
            m_flash_on = 1'b1;
        end else begin
            m_rem--;
            if (m_rem == 0) begin
                if (m_ph == 2) begin
                    m_dir = pick(m_dir, s);
                    m_ph  = 0;
                end else begin
                    m_ph++;
                end
                m_rem = dur(m_ph);
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [3*N-1:0] el;
        el = exp_lights();
        checks++;
        assert (lights === el) else begin
            errs++;
            $error("FAIL %s lights: got %h want %h", tag, lights, el);
        end
        checks++;
        assert (active_dir === 2'(m_dir)) else begin
            errs++;
            $error("FAIL %s active_dir: got %0d want %0d",
                   tag, active_dir, m_dir);
        end
        checks++;
        assert (phase === 2'(m_ph)) else begin
            errs++;
            $error("FAIL %s phase: got %0d want %0d", tag, phase, m_ph);
        end
    endtask

    task automatic step(input bit t, input logic [N-1:0] s, input bit fr,
                        input string tag);
        tick  = t;
        sense = s;
`ifdef TRAFFIC_FLASH_EN
        flash_req = fr;
`endif
        @(posedge clk);
        if (!rst_an) model_reset();
        else model_edge(t, s, fr);
        #1;
        check_model(tag);
    endtask

    initial begin
        rst_an = 1'b0;
        tick   = 1'b1;
        sense  = '0;
`ifdef TRAFFIC_FLASH_EN
        flash_req = 1'b0;
`endif
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_model("reset");
        checks++;
        assert (lights === 12'h921) else begin
            errs++;
            $error("FAIL reset_lights: got %h want %h", lights, 12'h921);
        end
        #2 rst_an = 1'b1;

        // full service of approach 0 with all demand present
        for (int i = 0; i < 8; i++) step(1'b1, 4'b1111, 1'b0, "svc0");
        checks++;
        assert (phase === 2'd1) else begin
            errs++;
            $error("FAIL yellow_at_8: got %0d want 1", phase);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 4'b1111, 1'b0, "svc0y");
        checks++;
        assert (phase === 2'd2) else begin
            errs++;
            $error("FAIL allred_at_12: got %0d want 2", phase);
        end
        step(1'b1, 4'b1111, 1'b0, "svc0r");
        checks++;
        assert (lights === 12'h90C) else begin
            errs++;
            $error("FAIL dir1_green_13: got %h want %h", lights, 12'h90C);
        end

        // only approach 3 has demand: skip straight to it
        for (int i = 0; i < 13; i++) step(1'b1, 4'b1000, 1'b0, "skip");
        checks++;
        assert (active_dir === 2'd3) else begin
            errs++;
            $error("FAIL skip_to_3: got %0d want 3", active_dir);
        end

        // no demand: plain round-robin over a full round
        for (int i = 0; i < 52; i++) step(1'b1, 4'b0000, 1'b0, "rr");
        checks++;
        assert (active_dir === 2'd3 && phase === 2'd0) else begin
            errs++;
            $error("FAIL rr_round: got dir %0d ph %0d want dir 3 ph 0",
                   active_dir, phase);
        end

        // tick every 4th clock stretches green to 32 clocks
        for (int i = 0; i < 31; i++)
            step(i % 4 == 3, 4'b0101, 1'b0, "slow");
        checks++;
        assert (phase === 2'd0) else begin
            errs++;
            $error("FAIL slow_green_31: got %0d want 0", phase);
        end
        step(1'b1, 4'b0101, 1'b0, "slow_end");
        checks++;
        assert (phase === 2'd1) else begin
            errs++;
            $error("FAIL slow_green_32: got %0d want 1", phase);
        end

        // tick held low: everything frozen
        for (int i = 0; i < 30; i++) step(1'b0, 4'($urandom), 1'b0, "hold");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit fr;
            fr = 1'b0;
`ifdef TRAFFIC_FLASH_EN
            fr = ($urandom_range(0, 15) == 0);
`endif
            step($urandom_range(0, 2) != 0, 4'($urandom), fr, "rand");
        end
        step(1'b1, 4'b0000, 1'b0, "rand_exit");
        step(1'b1, 4'b0000, 1'b0, "rand_exit");

        // reach approach 2 yellow, then reset asynchronously
        for (int i = 0; i < 200 && !(m_ph == 1 && m_dir == 2); i++)
            step(1'b1, 4'b1111, 1'b0, "seek");
        checks++;
        assert (phase === 2'd1 && active_dir === 2'd2) else begin
            errs++;
            $error("FAIL seek_dir2_yellow: got dir %0d ph %0d want 2/1",
                   active_dir, phase);
        end
        #2 rst_an = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        checks++;
        assert (lights === 12'h921) else begin
            errs++;
            $error("FAIL async_rst_lights: got %h want %h", lights, 12'h921);
        end
        step(1'b1, 4'b1111, 1'b0, "in_rst");
        #2 rst_an = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b1, 4'b1111, 1'b0, "post_rst");

`ifdef TRAFFIC_FLASH_EN
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0110, 1'b0, "pre_fl");
        step(1'b1, 4'b0110, 1'b1, "fl_enter");
        checks++;
        assert (lights === 12'h492 && phase === 2'd3) else begin
            errs++;
            $error("FAIL flash_enter: got %h ph %0d want 492 ph 3",
                   lights, phase);
        end
        for (int i = 0; i < 12; i++) step(1'b1, 4'b0110, 1'b1, "flash");
        step(1'b1, 4'b0110, 1'b0, "fl_exit");
        checks++;
        assert (phase === 2'd2) else begin
            errs++;
            $error("FAIL flash_exit: got %0d want 2", phase);
        end
        for (int i = 0; i < 20; i++) step(1'b1, 4'b0110, 1'b0, "post_fl");
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
